// File: rtl/counter_pkg.sv
// Shared constants and terminal-value helpers for the up/down counter.
package counter_pkg;

   localparam int DEFAULT_WIDTH = 4;
   localparam int MAX_WIDTH     = 16;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Helpers return a MAX_WIDTH value; callers truncate to their own width.
   function automatic logic [MAX_WIDTH-1:0] allOnes(input int width);
      return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
   endfunction

   function automatic logic [MAX_WIDTH-1:0] zeroVal(input int width);
      return {MAX_WIDTH{1'b0}} & ({MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width));
   endfunction

endpackage

// File: rtl/counter_next.sv
// Next-state logic for the counter: load, up/down step, wrap or saturate.
// Saturating behaviour is selected by defining COUNTER_SATURATE_EN.
module counter_next
   import counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] i_q,
   input  logic             i_ld,
   input  logic             i_upDown,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_nextQ,
   output logic             o_nextTc
);

   logic [WIDTH-1:0] w_max;
   logic [WIDTH-1:0] w_min;

   assign w_max = WIDTH'(allOnes(WIDTH));
   assign w_min = WIDTH'(zeroVal(WIDTH));

   // A step that hits a limit either wraps or sticks; both raise tc.
   always_comb begin
      o_nextQ  = i_q;
      o_nextTc = 1'b0;
      if (i_ld) begin
         o_nextQ = i_d;
      end else if (i_upDown == DIR_UP) begin
         if (i_q == w_max) begin
            o_nextTc = 1'b1;
`ifdef COUNTER_SATURATE_EN
            o_nextQ  = w_max;
`else
            o_nextQ  = w_min;
`endif
         end else begin
            o_nextQ = i_q + WIDTH'(1);
         end
      end else begin
         if (i_q == w_min) begin
            o_nextTc = 1'b1;
`ifdef COUNTER_SATURATE_EN
            o_nextQ  = w_min;
`else
            o_nextQ  = w_max;
`endif
         end else begin
            o_nextQ = i_q - WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/counter.sv
// Loadable up/down counter with registered terminal-count flag.
// Define COUNTER_SATURATE_EN to saturate at the limits instead of wrapping.
module counter
   import counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic             upDown,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc
);

   logic [WIDTH-1:0] r_q;
   logic             r_tc;
   logic [WIDTH-1:0] w_nextQ;
   logic             w_nextTc;

   counter_next #(
      .WIDTH(WIDTH)
   ) u_next (
      .i_q      (r_q),
      .i_ld     (ld),
      .i_upDown (upDown),
      .i_d      (d),
      .o_nextQ  (w_nextQ),
      .o_nextTc (w_nextTc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q  <= '0;
         r_tc <= 1'b0;
      end else begin
         r_q  <= w_nextQ;
         r_tc <= w_nextTc;
      end
   end

   assign q  = r_q;
   assign tc = r_tc;

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: directed scenarios plus random stimulus
// compared against an arithmetic reference model (honours COUNTER_SATURATE_EN).
module tb_counter;

   localparam int W    = 4;
   localparam int MAXV = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst;
   logic         ld;
   logic         upDown;
   logic [W-1:0] d;
   logic [W-1:0] q;
   logic         tc;

   int checks   = 0;
   int failures = 0;
   int modelQ   = 0;
   int modelTc  = 0;

   always #5 clk = ~clk;

   counter #(
      .WIDTH(W)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .ld     (ld),
      .upDown (upDown),
      .d      (d),
      .q      (q),
      .tc     (tc)
   );

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Reference: plain integer arithmetic on the count value.
   task automatic modelStep(input bit l, input bit u, input int dv);
      int nxt;
      if (l) begin
         modelQ  = dv;
         modelTc = 0;
      end else begin
         nxt = u ? modelQ + 1 : modelQ - 1;
         if (nxt > MAXV || nxt < 0) begin
            modelTc = 1;
`ifdef COUNTER_SATURATE_EN
            modelQ  = (nxt > MAXV) ? MAXV : 0;
`else
            modelQ  = (nxt + MAXV + 1) % (MAXV + 1);
`endif
         end else begin
            modelTc = 0;
            modelQ  = nxt;
         end
      end
   endtask

   task automatic applyStimulus(input bit r, input bit l, input bit u,
                                input logic [W-1:0] dv, input string tag);
      @(negedge clk);
      rst    = r;
      ld     = l;
      upDown = u;
      d      = dv;
      if (r) begin
         #1;
         modelQ  = 0;
         modelTc = 0;
         checkOutput({tag, "_asyncQ"}, int'(q), 0);
         checkOutput({tag, "_asyncTc"}, int'(tc), 0);
      end
      @(posedge clk);
      if (!r) modelStep(l, u, int'(dv));
      #1;
      checkOutput({tag, "_q"}, int'(q), modelQ);
      checkOutput({tag, "_tc"}, int'(tc), modelTc);
   endtask

   initial begin
      rst    = 1'b1;
      ld     = 1'b0;
      upDown = 1'b1;
      d      = '0;
      #1;
      checkOutput("resetQ", int'(q), 0);
      checkOutput("resetTc", int'(tc), 0);

      // Release reset and count up three, then down one.
      applyStimulus(0, 0, 1, 4'd0, "up1");
      applyStimulus(0, 0, 1, 4'd0, "up2");
      applyStimulus(0, 0, 1, 4'd0, "up3");
      checkOutput("upTo3", int'(q), 3);
      applyStimulus(0, 0, 0, 4'd0, "down1");
      checkOutput("downTo2", int'(q), 2);

      // Mid-cycle reset must clear without a clock edge.
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      modelQ  = 0;
      modelTc = 0;
      checkOutput("midResetQ", int'(q), 0);
      checkOutput("midResetTc", int'(tc), 0);
      applyStimulus(1, 1, 1, 4'd5, "holdRst1");
      applyStimulus(1, 1, 1, 4'd5, "holdRst2");

      // Down from zero after reset release.
      applyStimulus(0, 0, 0, 4'd9, "downWrap0");
`ifndef COUNTER_SATURATE_EN
      checkOutput("downWrapVal", int'(q), MAXV);
      checkOutput("downWrapTc", int'(tc), 1);
`endif
      applyStimulus(0, 0, 0, 4'd9, "downWrap1");
      applyStimulus(0, 0, 0, 4'd9, "downWrap2");

      // Load priority over counting, and held load.
      applyStimulus(0, 1, 0, 4'd7, "load7");
      applyStimulus(0, 1, 1, 4'b1010, "loadPri");
      checkOutput("loadPriVal", int'(q), 10);
      applyStimulus(0, 1, 1, 4'b1010, "loadHeld");

      // Load of a terminal value never raises tc; then step over the limit.
      applyStimulus(0, 1, 1, 4'd15, "load15");
      applyStimulus(0, 0, 1, 4'd0, "upLimit1");
      applyStimulus(0, 0, 1, 4'd0, "upLimit2");
      applyStimulus(0, 1, 0, 4'd0, "load0");
      applyStimulus(0, 0, 0, 4'd0, "downLimit1");
      applyStimulus(0, 0, 0, 4'd0, "downLimit2");

      // Random traffic with occasional loads and resets.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 39) == 0),
                       ($urandom_range(0, 7) == 0),
                       1'($urandom_range(0, 1)),
                       W'($urandom_range(0, MAXV)),
                       "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
